// File: rtl/decode.sv
// MIPS decode stage: 32x32 register file with two combinational read ports and field extracts.
// Optional same-cycle write bypass on the read ports is enabled by defining DECODE_WRITE_BYPASS_EN.
module decode (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instruction,
  input  logic [31:0] writeData,
  input  logic [4:0]  writeRegister,
  input  logic        regWrite,
  output logic [31:0] readData1,
  output logic [31:0] readData2,
  output logic [4:0]  insaddress1,
  output logic [4:0]  insaddress2,
  output logic [29:0] signExt
);

  logic [31:0] regFile [32];
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [5:0]  unusedOpcode;
  logic        writeEn;

  assign rs           = instruction[25:21];
  assign rt           = instruction[20:16];
  assign unusedOpcode = instruction[31:26];

  assign insaddress1 = instruction[20:16];
  assign insaddress2 = instruction[15:11];
  assign signExt     = {{14{instruction[15]}}, instruction[15:0]};

  // Index 0 is never written, so it only ever holds its reset value.
  assign writeEn = regWrite && (writeRegister != 5'd0);

  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the whole array is cleared on reset because software may read any
      // register before writing it; this rules out a RAM macro for the file.
      for (int i = 0; i < 32; i++) begin
        regFile[i] <= '0;
      end
    end else if (writeEn) begin
      regFile[writeRegister] <= writeData;
    end
  end

  // Register 0 is forced to zero on read so it is clean even before the first reset.
  always_comb begin
    readData1 = (rs == 5'd0) ? 32'd0 : regFile[rs];
    readData2 = (rt == 5'd0) ? 32'd0 : regFile[rt];
`ifdef DECODE_WRITE_BYPASS_EN
    if (writeEn && !reset && (writeRegister == rs)) begin
      readData1 = writeData;
    end
    if (writeEn && !reset && (writeRegister == rt)) begin
      readData2 = writeData;
    end
`else
`endif
  end

endmodule

// File: tb/tb_decode.sv
// Directed self-checking bench for decode; expectations follow DECODE_WRITE_BYPASS_EN when defined.
module tb_decode;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instruction;
  logic [31:0] writeData;
  logic [4:0]  writeRegister;
  logic        regWrite;
  logic [31:0] readData1;
  logic [31:0] readData2;
  logic [4:0]  insaddress1;
  logic [4:0]  insaddress2;
  logic [29:0] signExt;

  int compared   = 0;
  int mismatched = 0;

  decode dut (
    .clk          (clk),
    .reset        (reset),
    .instruction  (instruction),
    .writeData    (writeData),
    .writeRegister(writeRegister),
    .regWrite     (regWrite),
    .readData1    (readData1),
    .readData2    (readData2),
    .insaddress1  (insaddress1),
    .insaddress2  (insaddress2),
    .signExt      (signExt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Inputs change 1 time unit after the edge, well away from the next one.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] mkInstr(input logic [4:0] rsF, input logic [4:0] rtF,
                                          input logic [15:0] imm);
    return {6'b000000, rsF, rtF, imm};
  endfunction

  task automatic writeReg(input logic [4:0] idx, input logic [31:0] data);
    regWrite      = 1'b1;
    writeRegister = idx;
    writeData     = data;
    tick();
    regWrite      = 1'b0;
  endtask

  logic [31:0] bypassExp;

  initial begin
    reset         = 1'b1;
    regWrite      = 1'b0;
    writeRegister = '0;
    writeData     = '0;
    instruction   = '0;
    tick();
    tick();

    // Field extracts and zeroed reads while reset is still asserted.
    instruction = 32'b000001_00100_01000_10000_00000_111111;
    #1;
    check("rst_insaddress1", {27'd0, insaddress1}, 32'd8);
    check("rst_insaddress2", {27'd0, insaddress2}, 32'd16);
    check("rst_signExt",     {2'b00, signExt},     32'h3FFF803F);
    check("rst_readData1",   readData1,            32'd0);
    check("rst_readData2",   readData2,            32'd0);
    reset = 1'b0;
    tick();

    writeReg(5'd2, 32'd10);
    instruction = mkInstr(5'd2, 5'd0, 16'h0000);
    #1;
    check("wr2_readData1", readData1, 32'd10);
    check("r0_readData2",  readData2, 32'd0);

    writeReg(5'd0, 32'hFFFFFFFF);
    instruction = mkInstr(5'd0, 5'd0, 16'h0000);
    #1;
    check("r0_readData1", readData1, 32'd0);
    check("r0_readData2", readData2, 32'd0);

    writeReg(5'd8, 32'd5);
    writeReg(5'd4, 32'd7);
    instruction = mkInstr(5'd4, 5'd8, 16'h0000);
    #1;
    check("rs4_readData1", readData1, 32'd7);
    check("rt8_readData2", readData2, 32'd5);
    instruction = mkInstr(5'd8, 5'd8, 16'h0000);
    #1;
    check("same_readData1", readData1, 32'd5);
    check("same_readData2", readData2, 32'd5);

    // Reset wins over a simultaneous write.
    reset         = 1'b1;
    regWrite      = 1'b1;
    writeRegister = 5'd4;
    writeData     = 32'd9;
    tick();
    reset    = 1'b0;
    regWrite = 1'b0;
    instruction = mkInstr(5'd4, 5'd2, 16'h0000);
    #1;
    check("rstwr_reg4", readData1, 32'd0);
    check("rstwr_reg2", readData2, 32'd0);

    // Same-cycle read of the register being written.
`ifdef DECODE_WRITE_BYPASS_EN
    bypassExp = 32'hA5A5A5A5;
`else
    bypassExp = 32'd0;
`endif
    instruction   = mkInstr(5'd3, 5'd5, 16'h0000);
    regWrite      = 1'b1;
    writeRegister = 5'd3;
    writeData     = 32'hA5A5A5A5;
    #1;
    check("pre_edge_readData1", readData1, bypassExp);
    check("pre_edge_readData2", readData2, 32'd0);
    tick();
    check("post_edge_readData1", readData1, 32'hA5A5A5A5);
    regWrite  = 1'b0;
    writeData = 32'd0;
    #1;
    check("held_readData1", readData1, 32'hA5A5A5A5);

    // regWrite low must not change the addressed register.
    tick();
    check("nowrite_reg3", readData1, 32'hA5A5A5A5);

    writeReg(5'd31, 32'h12345678);
    instruction = mkInstr(5'd31, 5'd3, 16'h0000);
    #1;
    check("reg31_readData1", readData1, 32'h12345678);
    check("reg3_readData2",  readData2, 32'hA5A5A5A5);

    // Positive immediate, no clock edge involved.
    instruction = mkInstr(5'd0, 5'd17, 16'h7FFF);
    #1;
    check("pos_signExt",     {2'b00, signExt},     32'h00007FFF);
    check("pos_insaddress1", {27'd0, insaddress1}, 32'd17);
    check("pos_insaddress2", {27'd0, insaddress2}, 32'd15);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/decode.md
DECODE -- requirements
Module: decode

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed as listed below.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset; sampled only on rising clk.
REQ-004 instruction  input  32  MIPS instruction word being decoded.
REQ-005 writeData  input  32  data to write into the register file.
REQ-006 writeRegister  input  5  destination register index for the write.
REQ-007 regWrite  input  1  write enable for the register file.
REQ-008 readData1  output  32  contents of register rs (instruction[25:21]).
REQ-009 readData2  output  32  contents of register rt (instruction[20:16]).
REQ-010 insaddress1  output  5  rt field, instruction[20:16], to the write-register select.
REQ-011 insaddress2  output  5  rd field, instruction[15:11], to the write-register select.
REQ-012 signExt  output  30  instruction[15:0] sign-extended to 30 bits.

Function
REQ-013 The register file SHALL hold 32 registers x 32 bits.
REQ-014 Register 0 SHALL always read 0; writes to index 0 SHALL be ignored.
REQ-015 On rising clk with reset=0 and regWrite=1, register[writeRegister] SHALL take writeData; regWrite=0 leaves all registers unchanged.
REQ-016 readData1 and readData2 SHALL be combinational from the current instruction fields and register contents, with zero cycles of latency.
REQ-017 insaddress1, insaddress2 and signExt SHALL be purely combinational field extracts and SHALL NOT depend on clk, reset or register state.
REQ-018 signExt SHALL be {14 copies of instruction[15], instruction[15:0]}.
REQ-019 rs and rt SHALL be read independently. When rs equals rt, both ports return the same value.
REQ-020 A write SHALL become visible on the read ports no later than immediately after the rising edge that performs it.

Reset
REQ-021 On rising clk with reset=1, all 32 registers SHALL clear to 0.
REQ-022 Reset SHALL take priority over a simultaneous write; the write is discarded.
REQ-023 While in reset, readData1 and readData2 SHALL read 0 after the first reset edge.
REQ-024 Field outputs SHALL continue to track instruction during reset.
REQ-025 Register contents before the first reset edge are undefined; the bench SHALL reset before checking read data.

Configuration
REQ-026 Macro DECODE_WRITE_BYPASS_EN SHALL control write bypass.
REQ-027 With DECODE_WRITE_BYPASS_EN defined, a read port SHALL return writeData combinationally in the same cycle when all of these hold: regWrite=1, reset=0, writeRegister!=0, and writeRegister equals that port's source index.
REQ-028 Without DECODE_WRITE_BYPASS_EN, read ports SHALL return the stored value; the new value appears only after the write edge.

Verification
REQ-029 Reset, then apply instruction=32'b000001_00100_01000_10000_00000_111111 -> insaddress1=8, insaddress2=16, signExt=30'h3FFF803F, readData1=readData2=0.
REQ-030 regWrite=1, writeRegister=2, writeData=10, one clk edge, then instruction rs=2 -> readData1=10.
REQ-031 Write 32'hFFFFFFFF to register 0, then read rs=0 -> readData1=0.
REQ-032 Write 5 to register 8 and 7 to register 4, then instruction rs=4, rt=8 -> readData1=7, readData2=5; next, reset=1 together with a write of 9 to register 4 -> register 4 reads 0.
REQ-033 With regWrite=1, writeRegister=3, writeData=32'hA5A5A5A5 and rs=3 before the edge -> readData1=32'hA5A5A5A5 if DECODE_WRITE_BYPASS_EN is defined, else the old value (0); after the edge both builds read 32'hA5A5A5A5.
REQ-034 Apply instruction[15:0]=16'h7FFF -> signExt=30'h00007FFF, with no clk edge required.
